// File: rtl/sha1_pkg.sv
// ---------------------------------------------------------------------------
// sha1_pkg
// Shared definitions for the SHA-1 round controller and its round decoder:
// FSM state encoding, the four round constants, f-function select codes,
// round-group boundaries and the default loop sizes.
// No ports; imported with "import sha1_pkg::*;".
// ---------------------------------------------------------------------------
package sha1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    // Round constants, one per 20-round group
    localparam logic [31:0] K0 = 32'h5A827999;
    localparam logic [31:0] K1 = 32'h6ED9EBA1;
    localparam logic [31:0] K2 = 32'h8F1BBCDC;
    localparam logic [31:0] K3 = 32'hCA62C1D6;

    // f-function select codes; the last group reuses Parity under its own code
    localparam logic [1:0] F_SEL_CH   = 2'd0;
    localparam logic [1:0] F_SEL_PAR  = 2'd1;
    localparam logic [1:0] F_SEL_MAJ  = 2'd2;
    localparam logic [1:0] F_SEL_PAR3 = 2'd3;

    // Round-group boundaries and the first round fed by the schedule recurrence
    localparam logic [6:0] RND_B1        = 7'd20;
    localparam logic [6:0] RND_B2        = 7'd40;
    localparam logic [6:0] RND_B3        = 7'd60;
    localparam logic [6:0] W_SCHED_START = 7'd16;

    // Default loop sizes
    localparam int ROUNDS_DEF    = 80;
    localparam int BLK_WORDS_DEF = 16;
    localparam int DIG_WORDS_DEF = 5;

endpackage

// File: rtl/sha1_round_decode.sv
// ---------------------------------------------------------------------------
// sha1_round_decode
// Purely combinational map from round index t to the per-round controls of
// the SHA-1 datapath. Kept separate so a datapath model can reuse it.
// Ports:
//   round  in  7   round index t (0..79)
//   f_sel  out 2   f-function select (Ch / Parity / Maj / Parity)
//   k      out 32  round constant K(t)
//   w_sel  out 1   0 = W from loaded buffer, 1 = W from schedule recurrence
// ---------------------------------------------------------------------------
module sha1_round_decode
    import sha1_pkg::*;
(
    input  logic [6:0]  round,
    output logic [1:0]  f_sel,
    output logic [31:0] k,
    output logic        w_sel
);

    always_comb begin
        f_sel = F_SEL_CH;
        k     = K0;
        if (round >= RND_B3) begin
            f_sel = F_SEL_PAR3;
            k     = K3;
        end else if (round >= RND_B2) begin
            f_sel = F_SEL_MAJ;
            k     = K2;
        end else if (round >= RND_B1) begin
            f_sel = F_SEL_PAR;
            k     = K1;
        end
    end

    assign w_sel = (round >= W_SCHED_START);

endmodule

// File: rtl/sha1_round_ctrl.sv
// ---------------------------------------------------------------------------
// sha1_round_ctrl
// Control sequencer for one SHA-1 block: loads 16 message words over a
// valid/ready handshake, steps the 80 compression rounds, pulses the
// H-accumulate, then presents the five digest word indices to the consumer.
// Holds only control state; no hash data passes through it.
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_start             begin a block (IDLE only), i_first_block loads IV
//   i_abort             synchronous return to IDLE, overrides everything
//   i_word_valid        message word present; o_word_ready / o_ld_en accept it
//   o_init_h            one-cycle IV load pulse in the first LOAD cycle
//   o_upd_en, o_round   round execute enable and index t
//   o_f_sel, o_k, o_w_sel  per-round decode of t (zero outside ROUND)
//   o_add_h             one-cycle H += {a,b,c,d,e} pulse
//   o_dig_valid, i_dig_ready, o_dig_sel  digest word readout handshake
//   o_busy              not in IDLE
//   o_done              one-cycle pulse after the last digest word is taken
// ---------------------------------------------------------------------------
module sha1_round_ctrl
    import sha1_pkg::*;
#(
    parameter int ROUNDS    = ROUNDS_DEF,
    parameter int BLK_WORDS = BLK_WORDS_DEF,
    parameter int DIG_WORDS = DIG_WORDS_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_first_block,
    input  logic        i_abort,
    input  logic        i_word_valid,
    output logic        o_word_ready,
    output logic        o_ld_en,
    output logic        o_init_h,
    output logic        o_upd_en,
    output logic [6:0]  o_round,
    output logic [1:0]  o_f_sel,
    output logic [31:0] o_k,
    output logic        o_w_sel,
    output logic        o_add_h,
    output logic        o_dig_valid,
    input  logic        i_dig_ready,
    output logic [2:0]  o_dig_sel,
    output logic        o_busy,
    output logic        o_done
);

    localparam int              WCNT_W = $clog2(BLK_WORDS);
    localparam logic [6:0]      T_LAST = 7'(ROUNDS - 1);
    localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(BLK_WORDS - 1);
    localparam logic [2:0]      D_LAST = 3'(DIG_WORDS - 1);

    state_t              state_q, state_d;
    logic [6:0]          t_q, t_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [2:0]          dig_q, dig_d;
    logic                init_h_q, init_h_d;
    logic                done_q, done_d;

    logic                in_round;
    logic [1:0]          dec_f_sel;
    logic [31:0]         dec_k;
    logic                dec_w_sel;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            t_q      <= '0;
            wcnt_q   <= '0;
            dig_q    <= '0;
            init_h_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            wcnt_q   <= wcnt_d;
            dig_q    <= dig_d;
            init_h_q <= init_h_d;
            done_q   <= done_d;
        end
    end

    // Counters are cleared on the state change that ends their phase, so
    // each phase always starts from 0 without relying on wrap-around.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        wcnt_d   = wcnt_q;
        dig_d    = dig_q;
        init_h_d = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d  = ST_LOAD;
                    init_h_d = i_first_block;
                end
            end
            ST_LOAD: begin
                if (i_word_valid) begin
                    if (wcnt_q == W_LAST) begin
                        state_d = ST_ROUND;
                        wcnt_d  = '0;
                        t_d     = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            ST_ROUND: begin
                if (t_q == T_LAST) begin
                    state_d = ST_FINAL;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            ST_FINAL: begin
                state_d = ST_OUT;
                dig_d   = '0;
            end
            ST_OUT: begin
                if (i_dig_ready) begin
                    if (dig_q == D_LAST) begin
                        state_d = ST_IDLE;
                        dig_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        dig_d = dig_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over every transition and suppresses any pending pulse
        if (i_abort) begin
            state_d  = ST_IDLE;
            t_d      = '0;
            wcnt_d   = '0;
            dig_d    = '0;
            init_h_d = 1'b0;
            done_d   = 1'b0;
        end
    end

    sha1_round_decode u_decode (
        .round (t_q),
        .f_sel (dec_f_sel),
        .k     (dec_k),
        .w_sel (dec_w_sel)
    );

    assign in_round     = (state_q == ST_ROUND);
    assign o_word_ready = (state_q == ST_LOAD);
    assign o_ld_en      = i_word_valid & o_word_ready;
    assign o_init_h     = init_h_q;
    assign o_upd_en     = in_round;
    assign o_round      = in_round ? t_q       : '0;
    assign o_f_sel      = in_round ? dec_f_sel : '0;
    assign o_k          = in_round ? dec_k     : '0;
    assign o_w_sel      = in_round & dec_w_sel;
    assign o_add_h      = (state_q == ST_FINAL);
    assign o_dig_valid  = (state_q == ST_OUT);
    assign o_dig_sel    = dig_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = done_q;

endmodule

// File: tb/tb_sha1_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sha1_round_ctrl
// Scoreboard bench for sha1_round_ctrl. The stimulus process pushes the
// expected control events (cycle, kind, value) into a queue as it drives
// each scenario; the monitor pops and compares one entry for every event
// output the DUT raises, and checks that IDLE presents reset-value outputs.
// ---------------------------------------------------------------------------
module tb_sha1_round_ctrl;

    localparam int EV_INIT = 0;
    localparam int EV_LD   = 1;
    localparam int EV_UPD  = 2;
    localparam int EV_ADDH = 3;
    localparam int EV_DIG  = 4;
    localparam int EV_DONE = 5;

    logic        clk = 1'b0;
    logic        rst_n, start, first_block, abort, word_valid, dig_ready;
    logic        word_ready, ld_en, init_h, upd_en, w_sel, add_h;
    logic        dig_valid, busy, done;
    logic [6:0]  round;
    logic [1:0]  f_sel;
    logic [31:0] k;
    logic [2:0]  dig_sel;

    typedef struct {
        int kind;
        int cyc;
        int data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_on   = 1'b0;
    int   s_cyc, r0, o0, acc, kk;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha1_round_ctrl dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_first_block (first_block),
        .i_abort       (abort),
        .i_word_valid  (word_valid),
        .o_word_ready  (word_ready),
        .o_ld_en       (ld_en),
        .o_init_h      (init_h),
        .o_upd_en      (upd_en),
        .o_round       (round),
        .o_f_sel       (f_sel),
        .o_k           (k),
        .o_w_sel       (w_sel),
        .o_add_h       (add_h),
        .o_dig_valid   (dig_valid),
        .i_dig_ready   (dig_ready),
        .o_dig_sel     (dig_sel),
        .o_busy        (busy),
        .o_done        (done)
    );

    function automatic string kname(input int kind);
        case (kind)
            EV_INIT: return "init_h";
            EV_LD:   return "ld_en";
            EV_UPD:  return "upd_en";
            EV_ADDH: return "add_h";
            EV_DIG:  return "dig_valid";
            default: return "done";
        endcase
    endfunction

    // Hand-written round tables
    function automatic logic [31:0] exp_k(input int t);
        if (t < 20) return 32'h5A827999;
        if (t < 40) return 32'h6ED9EBA1;
        if (t < 60) return 32'h8F1BBCDC;
        return 32'hCA62C1D6;
    endfunction

    function automatic logic [1:0] exp_f(input int t);
        if (t < 20) return 2'd0;
        if (t < 40) return 2'd1;
        if (t < 60) return 2'd2;
        return 2'd3;
    endfunction

    task automatic push(input int kind, input int c, input int d);
        sb_q.push_back('{kind, c, d});
    endtask

    // Full block with valid/ready held high, i_start in cycle s
    task automatic push_full(input int s, input bit with_init);
        if (with_init) push(EV_INIT, s + 1, 0);
        for (int i = 1; i <= 16; i++) push(EV_LD, s + i, 0);
        for (int t = 0; t < 80; t++) push(EV_UPD, s + 17 + t, t);
        push(EV_ADDH, s + 97, 0);
        for (int d = 0; d < 5; d++) push(EV_DIG, s + 98 + d, d);
        push(EV_DONE, s + 103, 0);
    endtask

    task automatic check_event(input int kind, input int data, input bit side_ok);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: got event at cycle %0d data %0d, required no event",
                     kname(kind), cyc, data);
            return;
        end
        e = sb_q.pop_front();
        if (e.kind != kind || e.cyc != cyc || e.data != data || !side_ok) begin
            n_fail++;
            $display("FAIL event_%s: got %s@%0d data=%0d side_ok=%0b, required %s@%0d data=%0d",
                     kname(e.kind), kname(kind), cyc, data, side_ok, kname(e.kind), e.cyc, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (init_h) check_event(EV_INIT, 0, busy);
            if (ld_en) check_event(EV_LD, 0, busy && word_ready);
            if (upd_en) begin
                check_event(EV_UPD, int'(round), busy);
                n_checks++;
                if (f_sel !== exp_f(int'(round)) || k !== exp_k(int'(round)) ||
                    w_sel !== (round >= 7'd16)) begin
                    n_fail++;
                    $display("FAIL decode_t%0d: got f_sel=%0d k=%h w_sel=%0b, required f_sel=%0d k=%h w_sel=%0b",
                             round, f_sel, k, w_sel, exp_f(int'(round)), exp_k(int'(round)),
                             (round >= 7'd16));
                end
            end
            if (add_h) check_event(EV_ADDH, 0, busy);
            if (dig_valid) check_event(EV_DIG, int'(dig_sel), busy);
            if (done) check_event(EV_DONE, 0, !busy);
            if (!busy) begin
                n_checks++;
                if ({word_ready, ld_en, init_h, upd_en, add_h, dig_valid, w_sel} !== 7'b0 ||
                    round !== 7'd0 || f_sel !== 2'd0 || k !== 32'd0 || dig_sel !== 3'd0) begin
                    n_fail++;
                    $display("FAIL idle_outputs@%0d: got rdy=%0b ld=%0b ih=%0b upd=%0b ah=%0b dv=%0b ws=%0b rnd=%0d f=%0d k=%h ds=%0d, required all 0",
                             cyc, word_ready, ld_en, init_h, upd_en, add_h, dig_valid, w_sel,
                             round, f_sel, k, dig_sel);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; first_block = 1'b0; abort = 1'b0;
        word_valid = 1'b0; dig_ready = 1'b0;
        repeat (3) step();
        rst_n  = 1'b1;
        mon_on = 1'b1;
        step(); step();

        // Nominal first block, everything held ready
        s_cyc = cyc;
        start = 1'b1; first_block = 1'b1; word_valid = 1'b1; dig_ready = 1'b1;
        push_full(s_cyc, 1'b1);
        step();
        start = 1'b0; first_block = 1'b0;
        goto(s_cyc + 103);
        step(); step();

        // Gappy word stream, stray i_start in ROUND, digest stall at index 2
        s_cyc = cyc;
        start = 1'b1; word_valid = 1'b0;
        step();
        start = 1'b0;
        acc = 0; kk = 0;
        while (acc < 16) begin
            word_valid = (kk % 2 == 0);
            if (word_valid) begin
                push(EV_LD, cyc, 0);
                acc++;
            end
            step();
            kk++;
        end
        word_valid = 1'b0;
        r0 = cyc;
        o0 = r0 + 81;
        for (int t = 0; t < 80; t++) push(EV_UPD, r0 + t, t);
        push(EV_ADDH, r0 + 80, 0);
        push(EV_DIG, o0, 0);
        push(EV_DIG, o0 + 1, 1);
        for (int i = 2; i <= 5; i++) push(EV_DIG, o0 + i, 2);
        push(EV_DIG, o0 + 6, 3);
        push(EV_DIG, o0 + 7, 4);
        push(EV_DONE, o0 + 8, 0);
        goto(r0 + 5);
        start = 1'b1;
        step();
        start = 1'b0;
        goto(o0 + 2);
        dig_ready = 1'b0;
        goto(o0 + 5);
        dig_ready = 1'b1;

        // Back-to-back start in the done cycle, not first block, aborted at t=40
        goto(o0 + 8);
        s_cyc = cyc;
        start = 1'b1; first_block = 1'b0; word_valid = 1'b1;
        for (int i = 1; i <= 16; i++) push(EV_LD, s_cyc + i, 0);
        for (int t = 0; t <= 40; t++) push(EV_UPD, s_cyc + 17 + t, t);
        step();
        start = 1'b0;
        goto(s_cyc + 17 + 40);
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (3) step();

        // Reset during LOAD after five accepted words
        s_cyc = cyc;
        start = 1'b1; first_block = 1'b1;
        push(EV_INIT, s_cyc + 1, 0);
        for (int i = 1; i <= 5; i++) push(EV_LD, s_cyc + i, 0);
        step();
        start = 1'b0; first_block = 1'b0;
        goto(s_cyc + 5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();

        // Recovery: a clean block after reset
        s_cyc = cyc;
        start = 1'b1; first_block = 1'b1;
        push_full(s_cyc, 1'b1);
        step();
        start = 1'b0; first_block = 1'b0;
        goto(s_cyc + 103);
        repeat (4) step();

        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d expected events never seen, required 0", sb_q.size());
        end
        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha1_round_ctrl.md
# sha1_round_ctrl

Sequencer for the SHA-1 compression datapath. It accepts one 512-bit block as 16 words over a valid/ready handshake, then steps the 80-round loop, driving:

- round index, f-function select, K constant and W-source select;
- the final H-accumulate step.

It finally reads the 160-bit digest out as five 32-bit words through the digest word selector. It sits between the host-side block feeder and the round datapath. It holds no hash data itself, only control state.

## Interface
Parameters:
- ROUNDS, 80, number of compression rounds (last round index = ROUNDS-1)
- BLK_WORDS, 16, message words loaded per block
- DIG_WORDS, 5, digest words read out

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_start  in  1  begin block; sampled only in IDLE
- i_first_block  in  1  sampled with i_start; 1 = load H0..H4 initial values
- i_abort  in  1  synchronous return to IDLE from any state
- i_word_valid  in  1  message word present on datapath input
- o_word_ready  out  1  controller accepts a word this cycle
- o_ld_en  out  1  write message word into W buffer (= i_word_valid & o_word_ready)
- o_init_h  out  1  one-cycle pulse: load H registers with IV
- o_upd_en  out  1  datapath executes one round this cycle
- o_round  out  7  current round index t
- o_f_sel  out  2  f-function select: 0 Ch, 1 Parity, 2 Maj, 3 Parity
- o_k  out  32  round constant K(t)
- o_w_sel  out  1  0 = W from loaded buffer, 1 = W from schedule recurrence
- o_add_h  out  1  one-cycle pulse: H += {a,b,c,d,e}
- o_dig_valid  out  1  digest word presented
- i_dig_ready  in  1  consumer accepts digest word
- o_dig_sel  out  3  digest word index 0..4, drives the 32-bit word selector
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse after last digest word accepted

## Operation
- States: IDLE, LOAD, ROUND, FINAL, OUT.
- IDLE:
  - i_start=1 moves to LOAD next cycle.
  - o_init_h is 1 during the first LOAD cycle iff i_first_block was 1 with i_start.
- LOAD:
  - o_word_ready=1.
  - The word counter (0..15) increments on each i_word_valid & o_word_ready.
  - The 16th accept moves to ROUND with t=0.
  - i_word_valid low stalls indefinitely.
- ROUND:
  - o_upd_en=1 every cycle; t increments 0..79 with no stall.
  - o_f_sel: 0 for t<20, 1 for t<40, 2 for t<60, 3 otherwise.
  - o_k: 32'h5A827999, 32'h6ED9EBA1, 32'h8F1BBCDC, 32'hCA62C1D6 on the same boundaries.
  - o_w_sel: 0 for t<16, 1 for t≥16.
  - t=79 moves to FINAL.
- FINAL: o_add_h=1 for exactly one cycle, then OUT with index 0.
- OUT:
  - o_dig_valid=1 and o_dig_sel = index.
  - Index increments on i_dig_ready.
  - Accept at index 4 moves to IDLE; o_done=1 in the first IDLE cycle.
- i_start outside IDLE is ignored.
- i_abort (any state) and reset both force IDLE next edge, counters to 0, no o_done, no o_add_h.
- i_abort has priority over every other transition.
- All counter widths are saturating-free. Counters wrap only through state change, never modulo.

## Timing
- Reset values: o_word_ready, o_ld_en, o_init_h, o_upd_en, o_add_h, o_dig_valid, o_busy, o_done = 0; o_round, o_f_sel, o_k, o_w_sel, o_dig_sel = 0.
- Outputs are decoded from registered state/counters. The only combinational output is o_ld_en, which is combinational from i_word_valid.
- i_start at cycle 0 gives o_word_ready at cycle 1.
- With i_word_valid and i_dig_ready held high:
  - LOAD occupies cycles 1–16.
  - ROUND occupies cycles 17–96 (t=0 at cycle 17).
  - FINAL is cycle 97.
  - OUT occupies cycles 98–102.
  - o_done pulses at cycle 103.
- i_start asserted in the o_done cycle is accepted: LOAD begins the next cycle, so back-to-back blocks need no gap cycle.
- o_dig_sel is stable while o_dig_valid=1 and i_dig_ready=0.

## Structure
- sha1_pkg holds:
  - state encoding;
  - K constants K0..K3;
  - F_SEL codes (CH, PAR, MAJ);
  - round boundaries 20/40/60;
  - ROUNDS, BLK_WORDS, DIG_WORDS defaults.
- One sub-module is natural: sha1_round_decode, a combinational block mapping t to {o_f_sel, o_k, o_w_sel}, reusable by the datapath testbench model.
- FSM and counters live in sha1_round_ctrl.

## Test plan
- Reset then i_start+i_first_block, valid/ready always 1 -> o_init_h at cycle 1, 16 o_ld_en pulses, o_round 0..79 in cycles 17–96, o_add_h at 97, o_dig_sel 0..4 at 98–102, o_done at 103.
- Round decode sweep -> o_f_sel/o_k change exactly at t=20, 40, 60 (values as listed); o_w_sel rises at t=16.
- i_word_valid toggled 1-0-1 in LOAD -> exactly 16 o_ld_en; ROUND starts the cycle after the 16th accept.
- i_dig_ready held 0 for 3 cycles at index 2 -> o_dig_sel stays 2, o_dig_valid stays 1, o_done delayed 3 cycles.
- i_abort at t=40, and separately i_rst_n=0 mid-LOAD -> IDLE next cycle, all outputs at reset values, no o_add_h, no o_done.
- i_start in the o_done cycle with i_first_block=0 -> LOAD next cycle, o_init_h stays 0; i_start during ROUND -> ignored.
